// File: rtl/fetch_sequencer.sv
// fetch_sequencer: divides the core clock into four one-hot quarter phases,
// holds the program counter, fetches from a combinational program ROM and
// loads the instruction register on the Q4->Q1 edge. It also handles
// branch/call/return/skip redirects and keeps a hardware return stack.
//
// Optional feature macro: STACK_GUARD_EN
//   defined   : the stack pointer saturates at 0..STACK_DEPTH. An overflowing
//               call or an underflowing ret sets the sticky o_stack_err.
//   undefined : the stack pointer wraps circularly and o_stack_err is tied 0.
//
// Phase states:
//   state | meaning
//   PH_Q1 | quarter 1, o_clk1 high, inst_reg freshly loaded
//   PH_Q2 | quarter 2, o_clk2 high
//   PH_Q3 | quarter 3, o_clk3 high
//   PH_Q4 | quarter 4, o_clk4 high, requests sampled on the edge leaving it
module fetch_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stall,
  input  logic [7:0]          i_rom_data,
  input  logic                i_branch_req,
  input  logic                i_call_req,
  input  logic                i_ret_req,
  input  logic                i_skip_req,
  input  logic [PC_WIDTH-1:0] i_branch_addr,
  output logic                o_clk1,
  output logic                o_clk2,
  output logic                o_clk3,
  output logic                o_clk4,
  output logic [PC_WIDTH-1:0] o_rom_addr,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [7:0]          o_inst_reg,
  output logic                o_stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
`ifdef STACK_GUARD_EN
  localparam int SP_W = IDX_W + 1;
`else
  localparam int SP_W = IDX_W;
`endif

  localparam logic [1:0] PH_Q1 = 2'd0;
  localparam logic [1:0] PH_Q2 = 2'd1;
  localparam logic [1:0] PH_Q3 = 2'd2;
  localparam logic [1:0] PH_Q4 = 2'd3;

  logic [1:0]          r_phase;
  logic [3:0]          r_strobe;
  logic [PC_WIDTH-1:0] r_pc;
  logic [7:0]          r_inst;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]     r_sp;

  logic                w_fetch_edge;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [IDX_W-1:0]    w_push_idx;
  logic [IDX_W-1:0]    w_pop_idx;
  logic                w_push_ok;
  logic                w_pop_ok;

  assign w_fetch_edge = !i_stall && (r_phase == PH_Q4);
  assign w_pc_inc     = r_pc + PC_WIDTH'(1);
  assign w_push_idx   = r_sp[IDX_W-1:0];
  // Low bits minus one also gives the right slot when a guarded sp sits at
  // STACK_DEPTH (low bits 0 -> last entry).
  assign w_pop_idx    = r_sp[IDX_W-1:0] - IDX_W'(1);

`ifdef STACK_GUARD_EN
  assign w_push_ok = (r_sp != SP_W'(STACK_DEPTH));
  assign w_pop_ok  = (r_sp != '0);
`else
  assign w_push_ok = 1'b1;
  assign w_pop_ok  = 1'b1;
`endif

  assign o_clk1     = r_strobe[0];
  assign o_clk2     = r_strobe[1];
  assign o_clk3     = r_strobe[2];
  assign o_clk4     = r_strobe[3];
  assign o_pc       = r_pc;
  assign o_rom_addr = r_pc;
  assign o_inst_reg = r_inst;

  // Quarter-phase counter with a registered one-hot strobe kept in lockstep.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase  <= PH_Q1;
      r_strobe <= 4'b0001;
    end else if (!i_stall) begin
      r_phase  <= r_phase + 2'd1;
      r_strobe <= {r_strobe[2:0], r_strobe[3]};
    end
  end

  // Fetch/redirect on the Q4->Q1 edge: priority ret > call > branch > skip > sequential.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc   <= '0;
      r_inst <= 8'h00;
      r_sp   <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (w_fetch_edge) begin
      if (i_ret_req) begin
        r_inst <= 8'h00;
        if (w_pop_ok) begin
          r_sp <= r_sp - SP_W'(1);
          r_pc <= r_stack[w_pop_idx];
        end else begin
          r_pc <= w_pc_inc;
        end
      end else if (i_call_req) begin
        r_inst <= 8'h00;
        r_pc   <= i_branch_addr;
        if (w_push_ok) begin
          // pc already points past the calling instruction, so it is the return address.
          r_stack[w_push_idx] <= r_pc;
          r_sp                <= r_sp + SP_W'(1);
        end
      end else if (i_branch_req) begin
        r_inst <= 8'h00;
        r_pc   <= i_branch_addr;
      end else if (i_skip_req) begin
        r_inst <= 8'h00;
        r_pc   <= w_pc_inc;
      end else begin
        r_inst <= i_rom_data;
        r_pc   <= w_pc_inc;
      end
    end
  end

`ifdef STACK_GUARD_EN
  logic r_stack_err;

  // Sticky error on a call into a full stack or a ret from an empty one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stack_err <= 1'b0;
    end else if (w_fetch_edge) begin
      if ((i_ret_req && !w_pop_ok) || (!i_ret_req && i_call_req && !w_push_ok))
        r_stack_err <= 1'b1;
    end
  end

  assign o_stack_err = r_stack_err;
`else
  assign o_stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by randomized
// requests, checked every clock against a behavioural model of the fetch stage.
module tb_fetch_sequencer;
  localparam int PCW   = 8;
  localparam int DEPTH = 4;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, stall, branch_req, call_req, ret_req, skip_req;
  logic [PCW-1:0] branch_addr;
  logic [7:0]     rom_data;
  logic           clk1, clk2, clk3, clk4, stack_err;
  logic [PCW-1:0] rom_addr, pc;
  logic [7:0]     inst_reg;
  logic [7:0]     rom [256];

  assign rom_data = rom[rom_addr];

  fetch_sequencer #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_rom_data(rom_data),
    .i_branch_req(branch_req), .i_call_req(call_req), .i_ret_req(ret_req),
    .i_skip_req(skip_req), .i_branch_addr(branch_addr),
    .o_clk1(clk1), .o_clk2(clk2), .o_clk3(clk3), .o_clk4(clk4),
    .o_rom_addr(rom_addr), .o_pc(pc), .o_inst_reg(inst_reg), .o_stack_err(stack_err)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: quarter index 0..3, pc, instruction, return stack as
  // an array addressed by an integer depth count.
  int       m_ph;
  logic [7:0] m_pc, m_inst;
  logic [7:0] m_stk [DEPTH];
  int       m_sp;
  logic     m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_ph = 0; m_pc = 0; m_inst = 0; m_sp = 0; m_err = 0;
      for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
    end else if (!stall) begin
      if (m_ph == 3) begin
        if (ret_req) begin
          m_inst = 0;
          if (GUARD && m_sp == 0) begin
            m_pc  = m_pc + 8'd1;
            m_err = 1;
          end else begin
            m_sp = GUARD ? m_sp - 1 : (m_sp + DEPTH - 1) % DEPTH;
            m_pc = m_stk[m_sp % DEPTH];
          end
        end else if (call_req) begin
          m_inst = 0;
          if (GUARD && m_sp == DEPTH) m_err = 1;
          else begin
            m_stk[m_sp % DEPTH] = m_pc;
            m_sp = GUARD ? m_sp + 1 : (m_sp + 1) % DEPTH;
          end
          m_pc = branch_addr;
        end else if (branch_req) begin
          m_inst = 0; m_pc = branch_addr;
        end else if (skip_req) begin
          m_inst = 0; m_pc = m_pc + 8'd1;
        end else begin
          m_inst = rom[m_pc]; m_pc = m_pc + 8'd1;
        end
      end
      m_ph = (m_ph + 1) % 4;
    end
  endtask

  task automatic compare_all();
    chk("phase_onehot", {28'd0, clk4, clk3, clk2, clk1}, 32'(1 << m_ph));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("inst_reg", 32'(inst_reg), 32'(m_inst));
    chk("stack_err", 32'(stack_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    stall = 0; branch_req = 0; call_req = 0; ret_req = 0; skip_req = 0;
  endtask

  task automatic to_q4();
    for (int i = 0; i < 4 && m_ph != 3; i++) tick();
  endtask

  // One request issued on the Q4->Q1 edge.
  task automatic req_at_q4(input int kind, input logic [7:0] addr);
    to_q4();
    branch_addr = addr;
    case (kind)
      0: branch_req = 1;
      1: call_req   = 1;
      2: ret_req    = 1;
      default: skip_req = 1;
    endcase
    tick();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(1, 255));
    rom[0] = 8'hA0; rom[1] = 8'hA1; rom[2] = 8'hA2;
    idle();
    branch_addr = 0;
    rst_n = 0;
    tick(); tick();
    chk("rst_clk1", 32'(clk1), 32'd1);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_inst", 32'(inst_reg), 32'd0);

    // Free run: 12 clocks
    rst_n = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) chk("inst_A0", 32'(inst_reg), 32'hA0);
      if (i == 8) chk("inst_A1", 32'(inst_reg), 32'hA1);
    end
    chk("inst_A2", 32'(inst_reg), 32'hA2);

    // Stall in Q2 for 5 clocks
    tick();
    stall = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_q2", 32'(clk2), 32'd1);
    chk("stall_pc", 32'(pc), 32'd3);
    stall = 0;
    tick();
    chk("resume_q3", 32'(clk3), 32'd1);

    // Branch to 0x40
    req_at_q4(0, 8'h40);
    chk("br_nop", 32'(inst_reg), 32'd0);
    chk("br_pc", 32'(pc), 32'h40);
    for (int i = 0; i < 4; i++) tick();
    chk("br_fetch", 32'(inst_reg), 32'(rom[8'h40]));

    // Call 0x20 from pc=0x05, then return
    req_at_q4(0, 8'h05);
    req_at_q4(1, 8'h20);
    chk("call_pc", 32'(pc), 32'h20);
    for (int i = 0; i < 4; i++) tick();
    req_at_q4(2, 8'h00);
    chk("ret_pc", 32'(pc), 32'h05);
    chk("ret_nop", 32'(inst_reg), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("ret_fetch", 32'(inst_reg), 32'(rom[8'h05]));

    // Skip at pc=0x10; branch requested outside Q4 is ignored
    req_at_q4(0, 8'h10);
    req_at_q4(3, 8'h00);
    chk("skip_nop", 32'(inst_reg), 32'd0);
    chk("skip_pc", 32'(pc), 32'h11);
    tick();
    branch_req = 1; branch_addr = 8'h77;
    tick();
    idle();
    chk("q2_branch_ignored", 32'(pc), 32'h11);

    // DEPTH+1 nested calls then unwind
    for (int i = 0; i <= DEPTH; i++) req_at_q4(1, 8'(8'h80 + 8'(i * 16)));
    chk("deep_err", 32'(stack_err), 32'(GUARD));
    for (int i = 0; i <= DEPTH; i++) req_at_q4(2, 8'h00);
    chk("unwind_err", 32'(stack_err), 32'(GUARD));

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      stall       = ($urandom_range(0, 7) == 0);
      ret_req     = ($urandom_range(0, 5) == 0);
      call_req    = ($urandom_range(0, 4) == 0);
      branch_req  = ($urandom_range(0, 4) == 0);
      skip_req    = ($urandom_range(0, 3) == 0);
      branch_addr = 8'($urandom);
      tick();
    end
    rst_n = 1;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
